// File: rtl/qed_dup_checker.sv
// QED duplicate checker: buffers original-mode instructions, un-maps each
// duplicate-mode instruction against its buffered original and flags any divergence.
module qed_dup_checker #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          orig_valid,
  input  logic [31:0]   orig_instruction,
  output logic          orig_ready,
  input  logic          dup_valid,
  input  logic [31:0]   dup_instruction,
  output logic          cmp_valid,
  output logic          cmp_match,
  output logic          mismatch,
  output logic          overflow,
  output logic          underflow,
  output logic [AW:0]   pending,
  output logic [15:0]   match_count,
  output logic [31:0]   fail_orig_instruction
);

  typedef enum logic {ST_RUN, ST_FAIL} state_e;

  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic [31:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]  count_q, count_d;
  logic         cmp_valid_q, cmp_valid_d, cmp_match_q, cmp_match_d;
  logic         mismatch_q, mismatch_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic [15:0]  match_count_q, match_count_d;
  logic [31:0]  fail_orig_q, fail_orig_d;
  state_e       state_q, state_d;

  logic         full, empty, push, pop, pair_match;
  logic [31:0]  head;

  // A non-zero register must land in the upper half of the file; x0 stays x0.
  function automatic logic reg_ok(input logic [4:0] o, input logic [4:0] d);
    return (o == 5'd0) ? (d == 5'd0) : (d == {1'b1, o[3:0]});
  endfunction

  function automatic logic pair_ok(input logic [31:0] o, input logic [31:0] d);
    logic [31:0] cov;
    logic        ok, use_rd, use_rs1, use_rs2;
    cov     = '0;
    ok      = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (o[6:0])
      OP_B:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_I:  begin use_rs1 = 1'b1; use_rd  = 1'b1; end
      OP_J:  use_rd = 1'b1;
      OP_SW: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        ok = ok & (d[31:25] == {6'b000001, o[25]}) & (d[11:7] == o[11:7]);
        cov[31:25] = '1;
      end
      OP_LW: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        ok = ok & (d[31:20] == {6'b000001, o[25:20]});
        cov[31:20] = '1;
      end
      OP_R:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      OP_AUIPC: use_rd = 1'b1;
      OP_LUI:   use_rd = 1'b1;
      default:  ;
    endcase
    if (use_rd) begin
      ok = ok & reg_ok(o[11:7], d[11:7]);
      cov[11:7] = '1;
    end
    if (use_rs1) begin
      ok = ok & reg_ok(o[19:15], d[19:15]);
      cov[19:15] = '1;
    end
    if (use_rs2) begin
      ok = ok & reg_ok(o[24:20], d[24:20]);
      cov[24:20] = '1;
    end
    // Everything not remapped must pass through untouched.
    ok = ok & ((d & ~cov) == (o & ~cov));
    return ok;
  endfunction

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign pop        = dup_valid && !empty;
  assign push       = orig_valid && (!full || pop);
  assign head       = mem_q[rd_ptr_q];
  assign pair_match = pair_ok(head, dup_instruction);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    cmp_valid_d   = 1'b0;
    cmp_match_d   = 1'b0;
    mismatch_d    = mismatch_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    match_count_d = match_count_q;
    fail_orig_d   = fail_orig_q;
    state_d       = state_q;
    if (clear) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      mismatch_d    = 1'b0;
      overflow_d    = 1'b0;
      underflow_d   = 1'b0;
      match_count_d = '0;
      fail_orig_d   = '0;
      state_d       = ST_RUN;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
      if (orig_valid && !push) overflow_d  = 1'b1;
      if (dup_valid && empty)  underflow_d = 1'b1;
      if (pop) begin
        cmp_valid_d = 1'b1;
        cmp_match_d = pair_match;
        if (!pair_match) begin
          mismatch_d = 1'b1;
          if (state_q == ST_RUN) begin
            state_d     = ST_FAIL;
            fail_orig_d = head;
          end
        end else if (state_q == ST_RUN && match_count_q != 16'hFFFF) begin
          match_count_d = match_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= orig_instruction;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cmp_valid_q   <= 1'b0;
      cmp_match_q   <= 1'b0;
      mismatch_q    <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      match_count_q <= '0;
      fail_orig_q   <= '0;
      state_q       <= ST_RUN;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cmp_valid_q   <= cmp_valid_d;
      cmp_match_q   <= cmp_match_d;
      mismatch_q    <= mismatch_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      match_count_q <= match_count_d;
      fail_orig_q   <= fail_orig_d;
      state_q       <= state_d;
    end
  end

  assign orig_ready            = !full;
  assign cmp_valid             = cmp_valid_q;
  assign cmp_match             = cmp_match_q;
  assign mismatch              = mismatch_q;
  assign overflow              = overflow_q;
  assign underflow             = underflow_q;
  assign pending               = count_q;
  assign match_count           = match_count_q;
  assign fail_orig_instruction = fail_orig_q;

endmodule
